// File: rtl/dac_update_sequencer.sv
// ---------------------------------------------------------------------------
// dac_update_sequencer
//
// Owns the I2C write engine of the 8-channel AD5675 DAC. Requesters only write
// a shadow table of channel codes. The sequencer serves pending channels one
// frame at a time, in round-robin order. For each frame it presents a latched
// 26-bit word and pulses the engine start. It then waits out the fixed
// transfer time before serving the next channel.
//
// Ports
//   CLOCK_01M   in   1   I2C bit-rate clock, all logic on posedge
//   reset       in   1   synchronous, active-high reset
//   wr_en       in   1   table write strobe (single cycle)
//   wr_chan     in   3   channel index for the write
//   wr_value    in  16   channel code
//   update_all  in   1   pulse, marks all 8 channels pending
//   i2c_start   out  1   engine start, high START_CYCLES cycles per frame
//   i2c_data    out 26   {DEV_ADDR, CMD, 1'b0, chan, code}
//   busy        out  1   high whenever the FSM is not IDLE
//   pending     out  8   per-channel pending mask
//   frame_done  out  1   one-cycle pulse when a frame's wait period ends
//   cur_chan    out  3   channel being (or last) served
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | pick the next pending channel after rr_ptr
// LOAD  | latch i2c_data from the table, clear the channel's pending bit
// START | hold i2c_start high for START_CYCLES cycles
// WAIT  | wait XFER_CYCLES cycles for the engine to finish the frame
// DONE  | pulse frame_done, return to IDLE
// ---------------------------------------------------------------------------
module dac_update_sequencer #(
  parameter logic [1:0] DEV_ADDR     = 2'b00,
  parameter logic [3:0] CMD          = 4'b0011,
  parameter int         START_CYCLES = 2,
  parameter int         XFER_CYCLES  = 50
) (
  input  logic        CLOCK_01M,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_chan,
  input  logic [15:0] wr_value,
  input  logic        update_all,
  output logic        i2c_start,
  output logic [25:0] i2c_data,
  output logic        busy,
  output logic [7:0]  pending,
  output logic        frame_done,
  output logic [2:0]  cur_chan
);

  localparam int MAX_CNT = (XFER_CYCLES > START_CYCLES) ? XFER_CYCLES : START_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [15:0]   r_table [8];
  logic [7:0]    r_pending;
  logic [2:0]    r_rr_ptr;
  logic [2:0]    r_cur_chan;
  logic [25:0]   r_data;
  logic          r_start;
  logic          r_busy;
  logic          r_frame_done;
  logic [CW-1:0] r_cnt;

  logic [7:0]    w_set_mask;
  logic [7:0]    w_clr_mask;
  logic [7:0]    w_pending_next;
  logic [2:0]    w_next_chan;
  logic          w_found;

  // Sets are applied after the LOAD clear, so a write landing on the channel
  // being loaded keeps its pending bit and gets its own later frame.
  always_comb begin
    w_set_mask = update_all ? 8'hFF : 8'h00;
    if (wr_en) w_set_mask[wr_chan] = 1'b1;
    w_clr_mask = 8'h00;
    if (r_state == S_LOAD) w_clr_mask[r_cur_chan] = 1'b1;
    w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;
  end

  // Round-robin search starting just after the last served channel; i = 8
  // wraps back onto rr_ptr itself.
  always_comb begin
    logic [2:0] idx;
    w_next_chan = r_rr_ptr;
    w_found     = 1'b0;
    idx         = r_rr_ptr;
    for (int i = 1; i <= 8; i++) begin
      idx = r_rr_ptr + 3'(i);
      if (!w_found && r_pending[idx]) begin
        w_next_chan = idx;
        w_found     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_01M) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_table[i] <= '0;
      r_pending    <= '0;
      r_rr_ptr     <= 3'd7;
      r_cur_chan   <= '0;
      r_data       <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cnt        <= '0;
      r_state      <= S_IDLE;
    end else begin
      r_pending    <= w_pending_next;
      r_frame_done <= 1'b0;
      if (wr_en) r_table[wr_chan] <= wr_value;

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_cur_chan <= w_next_chan;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Reads the pre-write table entry, so a colliding write is not sent now.
          r_data   <= {DEV_ADDR, CMD, 1'b0, r_cur_chan, r_table[r_cur_chan]};
          r_rr_ptr <= r_cur_chan;
          r_start  <= 1'b1;
          r_cnt    <= CW'(START_CYCLES - 1);
          r_state  <= S_START;
        end
        S_START: begin
          if (r_cnt == '0) begin
            r_start <= 1'b0;
            r_cnt   <= CW'(XFER_CYCLES - 1);
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i2c_start  = r_start;
  assign i2c_data   = r_data;
  assign busy       = r_busy;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;
  assign cur_chan   = r_cur_chan;

endmodule

// File: tb/tb_dac_update_sequencer.sv
module tb_dac_update_sequencer;

  logic        CLOCK_01M = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_chan = '0;
  logic [15:0] wr_value = '0;
  logic        update_all = 1'b0;
  logic        i2c_start;
  logic [25:0] i2c_data;
  logic        busy;
  logic [7:0]  pending;
  logic        frame_done;
  logic [2:0]  cur_chan;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_01M = ~CLOCK_01M;

  dac_update_sequencer dut (
    .CLOCK_01M (CLOCK_01M),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_chan   (wr_chan),
    .wr_value  (wr_value),
    .update_all(update_all),
    .i2c_start (i2c_start),
    .i2c_data  (i2c_data),
    .busy      (busy),
    .pending   (pending),
    .frame_done(frame_done),
    .cur_chan  (cur_chan)
  );

  function automatic logic [25:0] word(input logic [2:0] ch, input logic [15:0] code);
    return {2'b00, 4'b0011, 1'b0, ch, code};
  endfunction

  task automatic apply_reset();
    @(negedge CLOCK_01M);
    reset = 1'b1; wr_en = 1'b0; update_all = 1'b0;
    repeat (2) @(negedge CLOCK_01M);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the next negedge with the write captured.
  task automatic write_chan(input logic [2:0] ch, input logic [15:0] v);
    wr_en = 1'b1; wr_chan = ch; wr_value = v;
    @(negedge CLOCK_01M);
    wr_en = 1'b0;
  endtask

  // Waits for a rising edge of i2c_start; n is negedges elapsed.
  task automatic wait_rise(output int n);
    logic prev;
    prev = i2c_start;
    n = 0;
    while (n < 300) begin
      @(negedge CLOCK_01M);
      n++;
      if (i2c_start && !prev) return;
      prev = i2c_start;
    end
    checks++; errors++;
    $display("FAIL wait_rise: no i2c_start rise within %0d cycles", n);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!frame_done && k < 100) begin
      @(negedge CLOCK_01M);
      k++;
    end
    if (!frame_done) begin
      checks++; errors++;
      $display("FAIL wait_done: no frame_done within %0d cycles", k);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", i2c_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", pending); end
    checks++; if (i2c_data !== 26'h0) begin errors++; $display("FAIL reset_data: got %h want 0", i2c_data); end
    checks++; if (cur_chan !== 3'd0) begin errors++; $display("FAIL reset_cur_chan: got %0d want 0", cur_chan); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_single_write();
    int n, k;
    apply_reset();
    write_chan(3'd3, 16'hABCD);
    checks++; if (pending !== 8'h08) begin errors++; $display("FAIL single_pending_set: got %h want 08", pending); end
    wait_rise(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", n); end
    checks++; if (i2c_data !== word(3'd3, 16'hABCD)) begin errors++; $display("FAIL single_data: got %h want %h", i2c_data, word(3'd3, 16'hABCD)); end
    checks++; if (cur_chan !== 3'd3) begin errors++; $display("FAIL single_cur_chan: got %0d want 3", cur_chan); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL single_pending_clr: got %h want 00", pending); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge CLOCK_01M);
    checks++; if (i2c_start !== 1'b1) begin errors++; $display("FAIL single_start_c2: got %b want 1", i2c_start); end
    @(negedge CLOCK_01M);
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL single_start_c3: got %b want 0", i2c_start); end
    k = 2;
    while (!frame_done && k < 100) begin
      @(negedge CLOCK_01M);
      k++;
    end
    checks++; if (k !== 52) begin errors++; $display("FAIL single_done_time: got %0d want 52", k); end
    checks++; if (i2c_data !== word(3'd3, 16'hABCD)) begin errors++; $display("FAIL single_data_done: got %h want %h", i2c_data, word(3'd3, 16'hABCD)); end
    @(negedge CLOCK_01M);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
  endtask

  task automatic test_update_all();
    int n;
    logic [7:0] exp_p;
    apply_reset();
    update_all = 1'b1;
    @(negedge CLOCK_01M);
    update_all = 1'b0;
    checks++; if (pending !== 8'hFF) begin errors++; $display("FAIL all_pending_set: got %h want ff", pending); end
    for (int ch = 0; ch < 8; ch++) begin
      wait_rise(n);
      exp_p = 8'hFF;
      exp_p = exp_p << (ch + 1);
      if (ch > 0) begin
        checks++; if (n !== 55) begin errors++; $display("FAIL all_period ch%0d: got %0d want 55", ch, n); end
      end
      checks++; if (cur_chan !== 3'(ch)) begin errors++; $display("FAIL all_order: got %0d want %0d", cur_chan, ch); end
      checks++; if (i2c_data !== word(3'(ch), 16'h0)) begin errors++; $display("FAIL all_data ch%0d: got %h want %h", ch, i2c_data, word(3'(ch), 16'h0)); end
      checks++; if (pending !== exp_p) begin errors++; $display("FAIL all_pending ch%0d: got %h want %h", ch, pending, exp_p); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL all_busy ch%0d: got %b want 1", ch, busy); end
    end
    wait_done();
  endtask

  task automatic test_rr_wrap();
    int n;
    apply_reset();
    write_chan(3'd5, 16'h5555);
    wait_rise(n);
    checks++; if (cur_chan !== 3'd5) begin errors++; $display("FAIL rr_first: got %0d want 5", cur_chan); end
    repeat (10) @(negedge CLOCK_01M);
    write_chan(3'd2, 16'h2222);
    write_chan(3'd6, 16'h6666);
    checks++; if (pending !== 8'h44) begin errors++; $display("FAIL rr_pending: got %h want 44", pending); end
    wait_rise(n);
    checks++; if (cur_chan !== 3'd6) begin errors++; $display("FAIL rr_second: got %0d want 6", cur_chan); end
    checks++; if (i2c_data !== word(3'd6, 16'h6666)) begin errors++; $display("FAIL rr_second_data: got %h want %h", i2c_data, word(3'd6, 16'h6666)); end
    wait_rise(n);
    checks++; if (cur_chan !== 3'd2) begin errors++; $display("FAIL rr_third: got %0d want 2", cur_chan); end
    checks++; if (i2c_data !== word(3'd2, 16'h2222)) begin errors++; $display("FAIL rr_third_data: got %h want %h", i2c_data, word(3'd2, 16'h2222)); end
    wait_done();
  endtask

  task automatic test_collision();
    int n;
    apply_reset();
    write_chan(3'd4, 16'h1111);
    @(negedge CLOCK_01M);
    checks++; if (busy !== 1'b1 || i2c_start !== 1'b0) begin errors++; $display("FAIL coll_load_cycle: got busy=%b start=%b want 1/0", busy, i2c_start); end
    write_chan(3'd4, 16'h2222);
    checks++; if (i2c_data !== word(3'd4, 16'h1111)) begin errors++; $display("FAIL coll_first_data: got %h want %h", i2c_data, word(3'd4, 16'h1111)); end
    checks++; if (pending !== 8'h10) begin errors++; $display("FAIL coll_pending_kept: got %h want 10", pending); end
    wait_rise(n);
    checks++; if (i2c_data !== word(3'd4, 16'h2222)) begin errors++; $display("FAIL coll_second_data: got %h want %h", i2c_data, word(3'd4, 16'h2222)); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL coll_pending_clr: got %h want 00", pending); end
    wait_done();
  endtask

  task automatic test_stability();
    int n, k, bad;
    logic [25:0] exp_d;
    apply_reset();
    write_chan(3'd1, 16'h0101);
    wait_rise(n);
    exp_d = word(3'd1, 16'h0101);
    bad = 0;
    k = 0;
    while (!frame_done && k < 100) begin
      wr_en = (k >= 2 && k < 20);
      wr_chan = 3'd1;
      wr_value = 16'hA000 + 16'(k);
      @(negedge CLOCK_01M);
      wr_en = 1'b0;
      if (i2c_data !== exp_d) bad++;
      k++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stab_hold: got %0d changed cycles want 0", bad); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL stab_done: got %b want 1", frame_done); end
    wait_rise(n);
    checks++; if (i2c_data !== word(3'd1, 16'hA013)) begin errors++; $display("FAIL stab_last_value: got %h want %h", i2c_data, word(3'd1, 16'hA013)); end
    wait_done();
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLOCK_01M);
      if (i2c_start) bad++;
    end
    checks++; if (bad != 0 || busy !== 1'b0) begin errors++; $display("FAIL stab_no_extra: got %0d start cycles busy=%b want 0/0", bad, busy); end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    apply_reset();
    write_chan(3'd7, 16'h7777);
    wait_rise(n);
    repeat (10) @(negedge CLOCK_01M);
    write_chan(3'd3, 16'h3333);
    reset = 1'b1;
    @(negedge CLOCK_01M);
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b want 0", i2c_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (pending !== 8'h00) begin errors++; $display("FAIL mid_pending: got %h want 00", pending); end
    checks++; if (i2c_data !== 26'h0) begin errors++; $display("FAIL mid_data: got %h want 0", i2c_data); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLOCK_01M);
      if (frame_done || i2c_start) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_frame: got %0d active cycles want 0", bad); end
    // Table must be cleared: every channel now sends code 0.
    update_all = 1'b1;
    @(negedge CLOCK_01M);
    update_all = 1'b0;
    bad = 0;
    for (int ch = 0; ch < 8; ch++) begin
      wait_rise(n);
      if (i2c_data !== word(3'(ch), 16'h0)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_table_clr: got %0d nonzero frames want 0", bad); end
    wait_done();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_update_all();
    test_rr_wrap();
    test_collision();
    test_stability();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
